memory_access: RTL

- Memory stage directly downstream of the execute stage.
- Consumes the ALU result, store data, branch target and zero flag.
- Resolves the branch decision and performs loads/stores against a multi-cycle data memory through a req/ack handshake.
- Stalls the pipeline while an access is outstanding. Load data is registered for writeback.

---
 rtl/memory_access_pkg.sv | 17 +
 rtl/memory_access_if.sv | 21 ++
 rtl/memory_access_timeout_counter.sv | 25 ++
 rtl/memory_access.sv | 131 +++++++++++++
 4 files changed

// File: rtl/memory_access_pkg.sv
// rtl/memory_access_pkg.sv - shared types and constants for the memory stage
package memory_access_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } ma_state_t;

    // Low address bits that must be zero for a 64-bit access
    localparam logic [2:0] ALIGN_MASK = 3'b111;

    function automatic logic is_misaligned(input logic [2:0] addr_lsbs);
        return (addr_lsbs & ALIGN_MASK) != 3'b000;
    endfunction

endpackage

// File: rtl/memory_access_if.sv
// rtl/memory_access_if.sv - data memory req/ack bus
interface memory_access_if #(
    parameter int N = 64
);
    logic         dm_req;
    logic         dm_we;
    logic [N-1:0] dm_addr;
    logic [N-1:0] dm_wdata;
    logic [N-1:0] dm_rdata;
    logic         dm_ack;

    modport master (
        output dm_req, dm_we, dm_addr, dm_wdata,
        input  dm_rdata, dm_ack
    );

    modport slave (
        input  dm_req, dm_we, dm_addr, dm_wdata,
        output dm_rdata, dm_ack
    );
endinterface

// File: rtl/memory_access_timeout_counter.sv
// rtl/memory_access_timeout_counter.sv - request timeout counter with terminal count
module memory_access_timeout_counter #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tc
);
    logic [7:0] count;

    // Count cycles spent waiting for an ack; clear wins over enable
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= 8'd0;
        end else if (clear) begin
            count <= 8'd0;
        end else if (enable) begin
            count <= count + 8'd1;
        end
    end

    assign tc = (count == 8'(TIMEOUT - 1));
endmodule

// File: rtl/memory_access.sv
// rtl/memory_access.sv - memory stage: branch resolve and multi-cycle load/store
module memory_access
    import memory_access_pkg::*;
#(
    parameter int N       = 64,
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         valid_M,
    input  logic         memRead_M,
    input  logic         memWrite_M,
    input  logic         Branch_M,
    input  logic         zero_M,
    input  logic [N-1:0] aluResult_M,
    input  logic [N-1:0] writeData_M,
    input  logic [N-1:0] PCBranch_M,
    output logic         PCSrc_M,
    output logic [N-1:0] PCBranch_out,
    output logic [N-1:0] aluResult_out,
    output logic [N-1:0] readData_M,
    output logic         stall_M,
    output logic         fault_M,
    memory_access_if.master dm
);
    ma_state_t    state, next_state;
    logic         memop, bad;
    logic         accept, capture_rd, load_zero, set_abort;
    logic         cnt_clr, cnt_en, tc;
    logic         abort_q, we_q;
    logic [N-1:0] addr_q, wdata_q, rdata_q;

    assign PCSrc_M       = valid_M & Branch_M & zero_M;
    assign PCBranch_out  = PCBranch_M;
    assign aluResult_out = aluResult_M;

    assign memop = valid_M & (memRead_M | memWrite_M);
    assign bad   = memop & ((memRead_M & memWrite_M) | is_misaligned(aluResult_M[2:0]));

    // Request side of the bus comes straight from flops
    assign dm.dm_req   = (state == REQ);
    assign dm.dm_we    = we_q;
    assign dm.dm_addr  = addr_q;
    assign dm.dm_wdata = wdata_q;
    assign readData_M  = rdata_q;

    memory_access_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (cnt_clr),
        .enable (cnt_en),
        .tc     (tc)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state, stall/fault and datapath strobes; ack outranks timeout
    always_comb begin
        next_state = state;
        stall_M    = 1'b0;
        fault_M    = 1'b0;
        accept     = 1'b0;
        capture_rd = 1'b0;
        load_zero  = 1'b0;
        set_abort  = 1'b0;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;
        case (state)
            IDLE: begin
                if (bad) begin
                    fault_M = 1'b1;
                end else if (memop) begin
                    accept     = 1'b1;
                    cnt_clr    = 1'b1;
                    stall_M    = 1'b1;
                    next_state = REQ;
                end
            end
            REQ: begin
                stall_M = 1'b1;
                if (dm.dm_ack) begin
                    capture_rd = ~we_q;
                    next_state = DONE;
                end else if (tc) begin
                    load_zero  = 1'b1;
                    set_abort  = 1'b1;
                    next_state = DONE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            DONE: begin
                fault_M    = abort_q;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Request latch, load data and abort flag
    always_ff @(posedge clk) begin
        if (!reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            abort_q <= 1'b0;
        end else begin
            if (accept) begin
                addr_q  <= aluResult_M;
                wdata_q <= writeData_M;
                we_q    <= memWrite_M;
            end
            if (capture_rd) begin
                rdata_q <= dm.dm_rdata;
            end else if (load_zero) begin
                rdata_q <= '0;
            end
            abort_q <= set_abort;
        end
    end
endmodule
